vx_fifo_lane_serializer: RTL and testbench

//  Downstream drain stage for the FIFO queue: pops wide multi-lane entries (LANES x ELEMW data + lane mask)
//  and emits only the active lanes, one per beat, on a valid/ready stream. Sits between a lane-packed

---
 rtl/vx_fifo_lane_serializer_pkg.sv | 14 +
 rtl/vx_fifo_lane_serializer_prio_enc.sv | 30 +++
 rtl/vx_fifo_lane_serializer.sv | 118 +++++++++++
 tb/tb_vx_fifo_lane_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_fifo_lane_serializer_pkg.sv
// ----------------------------------------------------------------------------
// vx_fifo_lane_serializer_pkg
//   Shared types for the FIFO lane serializer.
//   state_e : drain state. IDLE means no active lanes are held. SEND means at
//             least one held lane is still waiting to be emitted.
// ----------------------------------------------------------------------------
package vx_fifo_lane_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/vx_fifo_lane_serializer_prio_enc.sv
// ----------------------------------------------------------------------------
// vx_fifo_lane_serializer_prio_enc
//   Priority encoder that returns the index of the lowest set bit.
//   Ports:
//     data_i  [N-1:0]  request vector
//     index_o [W-1:0]  index of the lowest set bit, or 0 when data_i == 0
//     valid_o          at least one bit of data_i is set
// ----------------------------------------------------------------------------
module vx_fifo_lane_serializer_prio_enc #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] data_i,
    output logic [W-1:0] index_o,
    output logic         valid_o
);

    // The loop scans from the top bit down, so the lowest set bit is the last
    // one written and wins.
    always_comb begin
        index_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                index_o = W'(i);
            end
        end
        valid_o = |data_i;
    end

endmodule

// File: rtl/vx_fifo_lane_serializer.sv
// ----------------------------------------------------------------------------
// vx_fifo_lane_serializer
//   Drain stage for a lane-packed request FIFO. The block pops one wide entry
//   (LANES x ELEMW data plus a lane mask) and emits only the active lanes.
//   It sends one lane per beat, in ascending lane order, on a valid/ready
//   stream. When ready_out stays high it sustains one element per cycle.
//   Ports:
//     clk, reset            clock; synchronous active-high reset
//     fifo_empty            FIFO head is valid when low
//     fifo_data, fifo_mask  FIFO head entry; lane i at [i*ELEMW +: ELEMW]
//     fifo_pop              consume the FIFO head this cycle
//     valid_out, ready_out  output handshake; fire = valid_out & ready_out
//     data_out, lane_out    current element and its lane index
//     last_out              current element is the last active lane of its entry
// ----------------------------------------------------------------------------
module vx_fifo_lane_serializer
    import vx_fifo_lane_serializer_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int ELEMW = 32,
    localparam int LANEW = $clog2(LANES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [LANES*ELEMW-1:0] fifo_data,
    input  logic [LANES-1:0]       fifo_mask,
    output logic                   fifo_pop,
    output logic                   valid_out,
    output logic [ELEMW-1:0]       data_out,
    output logic [LANEW-1:0]       lane_out,
    output logic                   last_out,
    input  logic                   ready_out
);

    localparam logic [LANES-1:0] ONE = LANES'(1);

    state_e                 state_q, state_d;
    logic [LANES*ELEMW-1:0] data_q, data_d;
    logic [LANES-1:0]       rem_mask_q, rem_mask_d;

    logic [LANEW-1:0] lane_idx;
    logic             enc_valid;
    logic             single_bit;
    logic             fire;
    logic             load;

    vx_fifo_lane_serializer_prio_enc #(
        .N (LANES)
    ) u_prio_enc (
        .data_i  (rem_mask_q),
        .index_o (lane_idx),
        .valid_o (enc_valid)
    );

    // x & (x-1) clears the lowest set bit. A zero result means at most one
    // bit was set.
    assign single_bit = ((rem_mask_q & (rem_mask_q - ONE)) == '0);
    assign fire       = valid_out & ready_out;

    // A new entry loads when nothing is held, or when the final lane is
    // leaving this cycle. That second case removes the bubble between entries.
    assign load = ~fifo_empty & ((state_q == ST_IDLE) | (fire & last_out));

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data holding register is reset too. data_out is a mux
            // of it and must read 0 while in reset.
            state_q    <= ST_IDLE;
            data_q     <= '0;
            rem_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rem_mask_q <= rem_mask_d;
        end
    end

    // ---------------- next-state logic ----------------
    // NOTE: every always_comb output gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        data_d     = data_q;
        rem_mask_d = rem_mask_q;
        if (load) begin
            data_d     = fifo_data;
            rem_mask_d = fifo_mask;
        end else if (fire) begin
            // The emitted lane is always the lowest set bit.
            rem_mask_d = rem_mask_q & (rem_mask_q - ONE);
        end
        // A zero-mask entry loads straight back into IDLE and emits no beat.
        state_d = (rem_mask_d != '0) ? ST_SEND : ST_IDLE;
    end

    // ---------------- outputs ----------------
    // The element path is driven only from the holding registers. There is no
    // combinational path from the FIFO head to the element outputs.
    always_comb begin
        valid_out = (state_q == ST_SEND);
        data_out  = data_q[lane_idx*ELEMW +: ELEMW];
        lane_out  = lane_idx;
        last_out  = valid_out & single_bit;
        fifo_pop  = load & ~reset;
    end

    // ---------------- runtime checks ----------------
    a_no_pop_when_empty : assert property (@(posedge clk) disable iff (reset)
        !(fifo_pop && fifo_empty));
    a_valid_has_lanes : assert property (@(posedge clk) disable iff (reset)
        valid_out |-> (rem_mask_q != '0) && enc_valid);
    a_state_matches_mask : assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_SEND) == (rem_mask_q != '0));

endmodule

// File: tb/tb_vx_fifo_lane_serializer.sv
module tb_vx_fifo_lane_serializer;

    localparam int LANES = 4;
    localparam int ELEMW = 32;

    typedef struct {
        logic [LANES*ELEMW-1:0] data;
        logic [LANES-1:0]       mask;
    } entry_t;

    typedef struct {
        logic [1:0]       lane;
        logic [ELEMW-1:0] data;
        logic             last;
    } beat_t;

    logic                   clk;
    logic                   reset;
    logic                   fifo_empty;
    logic [LANES*ELEMW-1:0] fifo_data;
    logic [LANES-1:0]       fifo_mask;
    logic                   fifo_pop;
    logic                   valid_out;
    logic [ELEMW-1:0]       data_out;
    logic [1:0]             lane_out;
    logic                   last_out;
    logic                   ready_out;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    entry_t      fq[$];        // FIFO contents; head drives the DUT
    beat_t       sb[$];        // expected output beats, in order
    int unsigned beat_cyc[$];  // cycle stamp of each accepted beat
    int unsigned pop_cyc[$];   // cycle stamp of each pop

    vx_fifo_lane_serializer #(
        .LANES (LANES),
        .ELEMW (ELEMW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_mask  (fifo_mask),
        .fifo_pop   (fifo_pop),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .lane_out   (lane_out),
        .last_out   (last_out),
        .ready_out  (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Build one FIFO entry and its expected beats: active lanes in ascending
    // order, with last set on the highest active lane.
    task automatic push_entry(input logic [LANES*ELEMW-1:0] d, input logic [LANES-1:0] m);
        entry_t e;
        beat_t  b;
        int     hi;
        e.data = d;
        e.mask = m;
        fq.push_back(e);
        hi = -1;
        for (int i = 0; i < LANES; i++) if (m[i]) hi = i;
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) begin
                b.lane = 2'(i);
                b.data = d[i*ELEMW +: ELEMW];
                b.last = (i == hi);
                sb.push_back(b);
            end
        end
    endtask

    // FIFO model: sample pop at negedge, retire the head after the edge.
    initial begin : fifo_model
        logic pop_s;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        fifo_mask  = '0;
        forever begin
            @(negedge clk);
            pop_s = (fifo_pop === 1'b1);
            if (pop_s) begin
                check("pop_only_when_nonempty", fifo_empty, 1'b0);
                pop_cyc.push_back(cyc);
            end
            @(posedge clk);
            #2;
            if (pop_s && fq.size() > 0) fq.delete(0);
            fifo_empty = (fq.size() == 0);
            fifo_data  = (fq.size() > 0) ? fq[0].data : '0;
            fifo_mask  = (fq.size() > 0) ? fq[0].mask : '0;
        end
    end

    // Monitor: compare every presented beat with the scoreboard head.
    initial begin : monitor
        beat_t exp_b;
        forever begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    exp_b = sb[0];
                    check("lane_out", lane_out, exp_b.lane);
                    check("data_out", data_out, exp_b.data);
                    check("last_out", last_out, exp_b.last);
                    if (ready_out === 1'b1) begin
                        sb.delete(0);
                        beat_cyc.push_back(cyc);
                    end else begin
                        check("no_pop_under_backpressure", fifo_pop, 1'b0);
                    end
                end
            end
        end
    end

    task automatic clear_stamps();
        beat_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((fq.size() != 0 || sb.size() != 0 || valid_out !== 1'b0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drain_timeout"}, (n >= budget), 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: time limit reached with %0d checks", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        reset     = 1'b1;
        ready_out = 1'b1;

        // 1: reset held 3 cycles with a full-mask entry waiting at the head
        clear_stamps();
        push_entry({32'hF000_0003, 32'hF000_0002, 32'hF000_0001, 32'hF000_0000}, 4'hF);
        repeat (3) begin
            @(negedge clk);
            check("rst_valid_out", valid_out, 1'b0);
            check("rst_fifo_pop", fifo_pop, 1'b0);
        end
        check("rst_data_out", data_out, 32'h0);
        check("rst_lane_out", lane_out, 2'd0);
        check("rst_last_out", last_out, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_drain("t1", 50);
        check("t1_pops", pop_cyc.size(), 1);
        check("t1_beats", beat_cyc.size(), 4);

        // 2: sparse mask, one pop exactly one cycle ahead of the first beat
        clear_stamps();
        push_entry({32'hD3D3_0003, 32'hD2D2_0002, 32'hD1D1_0001, 32'hD0D0_0000}, 4'b1010);
        wait_drain("t2", 50);
        check("t2_pops", pop_cyc.size(), 1);
        check("t2_beats", beat_cyc.size(), 2);
        if (pop_cyc.size() == 1 && beat_cyc.size() == 2) begin
            check("t2_latency", beat_cyc[0] - pop_cyc[0], 1);
            check("t2_back_to_back", beat_cyc[1] - beat_cyc[0], 1);
        end

        // 3: two entries back to back, no bubble across the entry boundary
        clear_stamps();
        push_entry({32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}, 4'hF);
        push_entry({32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000}, 4'h1);
        wait_drain("t3", 50);
        check("t3_pops", pop_cyc.size(), 2);
        check("t3_beats", beat_cyc.size(), 5);
        if (beat_cyc.size() == 5) begin
            for (int i = 1; i < 5; i++) check("t3_no_bubble", beat_cyc[i] - beat_cyc[0], i);
        end

        // 4: backpressure for 3 cycles on the first beat
        clear_stamps();
        ready_out = 1'b0;
        push_entry({32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000}, 4'b0110);
        n = 0;
        while (valid_out !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t4_valid_timeout", (n >= 20), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_beats_while_stalled", beat_cyc.size(), 0);
        check("t4_pops_while_stalled", pop_cyc.size(), 1);
        ready_out = 1'b1;
        wait_drain("t4", 50);
        check("t4_pops", pop_cyc.size(), 1);
        check("t4_beats", beat_cyc.size(), 2);
        if (beat_cyc.size() == 2) check("t4_release_consecutive", beat_cyc[1] - beat_cyc[0], 1);

        // 5: a zero-mask entry between two single-lane entries
        clear_stamps();
        push_entry({32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000}, 4'h1);
        push_entry({32'h9999_9999, 32'h8888_8888, 32'h7777_7777, 32'h6666_6666}, 4'h0);
        push_entry({32'hE100_0003, 32'hE100_0002, 32'hE100_0001, 32'hE100_0000}, 4'h8);
        wait_drain("t5", 50);
        check("t5_pops", pop_cyc.size(), 3);
        check("t5_beats", beat_cyc.size(), 2);
        if (beat_cyc.size() == 2) check("t5_one_idle_cycle", beat_cyc[1] - beat_cyc[0], 2);
        if (pop_cyc.size() == 3) check("t5_pop_spacing", pop_cyc[2] - pop_cyc[0], 2);

        // 6: reset after the first of four beats drops the remaining lanes
        clear_stamps();
        push_entry({32'h5000_0003, 32'h5000_0002, 32'h5000_0001, 32'h5000_0000}, 4'hF);
        n = 0;
        while (beat_cyc.size() < 1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t6_first_beat_timeout", (n >= 20), 1'b0);
        reset     = 1'b1;
        ready_out = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        push_entry({32'h6000_0003, 32'h6000_0002, 32'h6000_0001, 32'h6000_0000}, 4'b0101);
        @(negedge clk);
        check("t6_valid_after_reset", valid_out, 1'b0);
        check("t6_no_pop_in_reset", fifo_pop, 1'b0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        ready_out = 1'b1;
        wait_drain("t6", 50);
        check("t6_pops", pop_cyc.size(), 2);
        check("t6_beats", beat_cyc.size(), 3);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
